arrow_input_decoder: RTL
========================

// Module: arrow_input_decoder
// PURPOSE
//  Upstream of the two per-player processors. Turns raw PS/2 scan-code bytes and two shake-sensor pins into
//  one-cycle arrow events per player, with make/break and E0-prefix tracking, typematic-repeat suppression
//  and a debounced shake input. Also produces the game-reset request.
// PARAMETERS
//  DEBOUNCE_CYCLES  100000  cycles a synchronised shake pin must be stable before it is accepted (10 ms @ 10 MHz)
//  CNT_W            17      width of each debounce counter; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//  clock                input   1  system clock (PLL output, 10 MHz)
//  resetn               input   1  asynchronous, active-low reset
//  ps2_key_data         input   8  received scan-code byte; valid only when ps2_key_pressed=1
//  ps2_key_pressed      input   1  one-cycle strobe, one per received byte
//  shake1_n, shake2_n   input   1  raw shake sensors, active-low, asynchronous to clock
//  player1_key_pressed  output  1  one-cycle event strobe, player 1
//  player1_arrow_input  output  8  event code, player 1; [7:3] always 0
//  player2_key_pressed  output  1  one-cycle event strobe, player 2
//  player2_arrow_input  output  8  event code, player 2; [7:3] always 0
//  game_reset_req       output  1  one-cycle pulse on make of 0x2D (R)
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; held mask=0; sync flops=1; debounced shake=1 (released); counters=0.
//  Event codes: up=3'b001, left=3'b010, down=3'b011, right=3'b100, shake=3'b101.
//  Key map: P1 (non-extended) W=1D up, A=1C left, S=1B down, D=23 right.
//           P2 (E0-extended) 75 up, 6B left, 72 down, 74 right.
//  Prefix FSM, advances only on a strobe cycle:
//   IDLE: E0->EXT; F0->BRK; other byte = make, non-extended.
//   EXT:  F0->EXT_BRK; other byte = make, extended; ->IDLE.
//   BRK:  byte = break, non-extended; ->IDLE.  EXT_BRK: byte = break, extended; ->IDLE.
//   Bytes AA and FA in any state are ignored and force IDLE.
//  Held mask: 8 bits, one per mapped key. A make sets the bit; a break clears it.
//   An arrow event fires only on a make whose bit was 0, so typematic repeats produce no event.
//   Unmapped codes change no state apart from the FSM.
//   Extension must match the map: P2 codes without E0 and P1 codes with E0 are unmapped.
//  Latency: the event strobe and its code are registered and appear on the cycle after the strobe of the final byte.
//   Outputs hold 0 in all other cycles.
//  game_reset_req: fires on a non-extended make of 2D, on the same cycle timing as events; it ignores the held mask.
//  Shake path (per player): 2-flop synchroniser, then a counter.
//   While the synced value differs from the debounced value the counter increments;
//   the debounced value takes the synced value when the counter reaches DEBOUNCE_CYCLES-1.
//   The counter clears whenever synced equals debounced.
//   A debounced 1->0 transition raises a shake request.
//  Simultaneous events (same player, same cycle): the key event wins.
//   The shake request is held in a 1-bit pending flag and emitted on the next cycle with no key event for that player.
//   A second shake arriving while pending is merged, not counted.
//  Players are independent: P1 and P2 strobes may assert on the same cycle.
//  Reset mid-sequence, e.g. after E0 or F0: the prefix is discarded and the held mask is cleared.
//   After reset, a held key's first repeat counts as a fresh make.
// TESTING
//  1. Strobe 1D -> cycle+1: player1_key_pressed=1, player1_arrow_input=8'h01; player2 stays 0.
//  2. Strobes E0,74 -> player2 event code 8'h04.
//     Then E0,74 again with no break -> no event.
//     Then E0,F0,74 followed by E0,74 -> exactly one new event.
//  3. Strobes F0,1C -> no event, A's held bit stays 0. Strobe 74 without E0 -> no P2 event.
//  4. DEBOUNCE_CYCLES=4: pull shake1_n low for 3 cycles -> nothing.
//     Hold it low for 8 cycles -> exactly one P1 event code 8'h05.
//     Force that shake to coincide with a 23 make -> code 04 first, 05 on the next cycle.
//  5. Strobe 2D -> game_reset_req pulses for exactly 1 cycle. Strobe E0,2D -> no pulse.
//  6. Strobe E0, assert resetn=0 for 1 cycle, then strobe 75 -> treated as non-extended: no event, all outputs 0.

Source files
------------

// File: rtl/arrow_input_decoder.sv
// PS/2 scan-code and shake-sensor front end. Emits one-cycle arrow/shake events per player and a game-reset request.
// Latency: key events appear 1 cycle after the final byte strobe. There is no backpressure; a coincident shake is deferred.

module shake_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw_n,
  output logic shake_fire
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1, sync2, deb;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      deb   <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= raw_n;
      sync2 <= sync1;
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // High during the cycle in which the debounced value is about to fall.
  assign shake_fire = (sync2 != deb) && (cnt == LAST) && deb;
endmodule

module arrow_input_decoder #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  input  logic       shake1_n,
  input  logic       shake2_n,
  output logic       player1_key_pressed,
  output logic [7:0] player1_arrow_input,
  output logic       player2_key_pressed,
  output logic [7:0] player2_arrow_input,
  output logic       game_reset_req
);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t     state;
  logic [7:0] held;
  logic [1:0] out_vld;
  logic [2:0] out_code [2];
  logic [1:0] pend;

  logic       is_ctrl, is_final, is_ext, is_brk, key_hit, make_new, reset_hit;
  logic [2:0] key_idx;
  logic [2:0] key_code;
  logic [1:0] key_evt, shake_fire;

  shake_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb1 (
    .clock(clock), .resetn(resetn), .raw_n(shake1_n), .shake_fire(shake_fire[0]));
  shake_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_deb2 (
    .clock(clock), .resetn(resetn), .raw_n(shake2_n), .shake_fire(shake_fire[1]));

  always_comb begin
    is_ctrl  = (ps2_key_data == 8'hAA) || (ps2_key_data == 8'hFA);
    is_ext   = (state == EXT) || (state == EXT_BRK);
    is_brk   = (state == BRK) || (state == EXT_BRK);
    is_final = ps2_key_pressed && !is_ctrl
             && !((state == IDLE) && ((ps2_key_data == 8'hE0) || (ps2_key_data == 8'hF0)))
             && !((state == EXT) && (ps2_key_data == 8'hF0));
    // Mask bits 0-3 are player 1 (up/left/down/right), 4-7 player 2.
    key_hit = 1'b1;
    key_idx = 3'd0;
    case ({is_ext, ps2_key_data})
      9'h01D:  key_idx = 3'd0;
      9'h01C:  key_idx = 3'd1;
      9'h01B:  key_idx = 3'd2;
      9'h023:  key_idx = 3'd3;
      9'h175:  key_idx = 3'd4;
      9'h16B:  key_idx = 3'd5;
      9'h172:  key_idx = 3'd6;
      9'h174:  key_idx = 3'd7;
      default: key_hit = 1'b0;
    endcase
    key_code  = {1'b0, key_idx[1:0]} + 3'd1;
    make_new  = is_final && key_hit && !is_brk && !held[key_idx];
    key_evt   = {make_new && key_idx[2], make_new && !key_idx[2]};
    reset_hit = is_final && !is_ext && !is_brk && (ps2_key_data == 8'h2D);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      held           <= '0;
      out_vld        <= '0;
      out_code[0]    <= '0;
      out_code[1]    <= '0;
      pend           <= '0;
      game_reset_req <= 1'b0;
    end else begin
      if (ps2_key_pressed) begin
        if (is_ctrl)
          state <= IDLE;
        else
          case (state)
            IDLE:    state <= (ps2_key_data == 8'hE0) ? EXT :
                              (ps2_key_data == 8'hF0) ? BRK : IDLE;
            EXT:     state <= (ps2_key_data == 8'hF0) ? EXT_BRK : IDLE;
            default: state <= IDLE;
          endcase
      end
      if (is_final && key_hit)
        held[key_idx] <= !is_brk;
      game_reset_req <= reset_hit;
      // Key events take priority; a shake waits in a single merged pending bit.
      for (int p = 0; p < 2; p++) begin
        if (key_evt[p]) begin
          out_vld[p]  <= 1'b1;
          out_code[p] <= key_code;
          pend[p]     <= pend[p] | shake_fire[p];
        end else if (pend[p] || shake_fire[p]) begin
          out_vld[p]  <= 1'b1;
          out_code[p] <= 3'b101;
          pend[p]     <= 1'b0;
        end else begin
          out_vld[p]  <= 1'b0;
          out_code[p] <= 3'b000;
        end
      end
    end
  end

  assign player1_key_pressed = out_vld[0];
  assign player1_arrow_input = {5'b0, out_code[0]};
  assign player2_key_pressed = out_vld[1];
  assign player2_arrow_input = {5'b0, out_code[1]};
endmodule
